// File: rtl/ex_div_ctrl.sv
// ============================================================================
// Module  : ex_div_ctrl
// Purpose : EX-stage sequencer for a radix-2 restoring 32-bit divider (div/mod,
//           signed/unsigned). Optional macro: DIV_EARLY_OUT_EN.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_div_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              div_req,
  input  logic [1:0]        div_op,
  input  logic [DATA_W-1:0] div_src1,
  input  logic [DATA_W-1:0] div_src2,
  input  logic              div_cancel,
  output logic              ex_exe_out_valid,
  output logic [DATA_W-1:0] div_result,
  output logic              div_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W:0]   r_rem;
  logic [DATA_W-1:0] r_quo;
  logic [DATA_W-1:0] r_dvs;
  logic [5:0]        r_cnt;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_mod;

  logic              w_signed;
  logic              w_neg1;
  logic              w_neg2;
  logic [DATA_W-1:0] w_abs1;
  logic [DATA_W-1:0] w_abs2;
  logic              w_dvs_zero;
  logic              w_early;
  logic              w_short;
  logic [DATA_W+1:0] w_shift;
  logic [DATA_W+1:0] w_diff;
  logic [DATA_W-1:0] w_quo_fix;
  logic [DATA_W-1:0] w_rem_fix;

  assign w_signed   = ~div_op[1];
  assign w_neg1     = w_signed & div_src1[DATA_W-1];
  assign w_neg2     = w_signed & div_src2[DATA_W-1];
  assign w_abs1     = w_neg1 ? (~div_src1 + 1'b1) : div_src1;
  assign w_abs2     = w_neg2 ? (~div_src2 + 1'b1) : div_src2;
  assign w_dvs_zero = (div_src2 == '0);

`ifdef DIV_EARLY_OUT_EN
  assign w_early = ~w_dvs_zero & (w_abs1 < w_abs2);
`else
  assign w_early = 1'b0;
`endif

  assign w_short = w_dvs_zero | w_early;

  // One extra headroom bit keeps the trial-subtract borrow unambiguous.
  assign w_shift = {r_rem, r_quo[DATA_W-1]};
  assign w_diff  = w_shift - {2'b00, r_dvs};

  assign w_quo_fix = r_neg_q ? (~r_quo + 1'b1) : r_quo;
  assign w_rem_fix = r_neg_r ? (~r_rem[DATA_W-1:0] + 1'b1) : r_rem[DATA_W-1:0];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (div_req) w_state_nxt = w_short ? S_DONE : S_BUSY;
      S_BUSY: begin
        if (!div_req)            w_state_nxt = S_IDLE;
        else if (r_cnt == 6'd31) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (div_cancel) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_mod   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && div_req && !div_cancel) begin
        r_mod <= div_op[0];
        r_cnt <= '0;
        r_dvs <= w_abs2;
        if (w_short) begin
          // Short paths present raw values: clearing the flags bypasses the fix-up.
          r_quo   <= w_dvs_zero ? '1 : '0;
          r_rem   <= {1'b0, div_src1};
          r_neg_q <= 1'b0;
          r_neg_r <= 1'b0;
        end else begin
          r_quo   <= w_abs1;
          r_rem   <= '0;
          r_neg_q <= w_neg1 ^ w_neg2;
          r_neg_r <= w_neg1;
        end
      end else if (r_state == S_BUSY && div_req && !div_cancel) begin
        r_cnt <= r_cnt + 6'd1;
        if (!w_diff[DATA_W+1]) begin
          r_rem <= w_diff[DATA_W:0];
          r_quo <= {r_quo[DATA_W-2:0], 1'b1};
        end else begin
          r_rem <= w_shift[DATA_W:0];
          r_quo <= {r_quo[DATA_W-2:0], 1'b0};
        end
      end
    end
  end

  assign ex_exe_out_valid = ~div_req | (r_state == S_DONE) | div_cancel;
  assign div_busy         = (r_state == S_BUSY);
  assign div_result       = (r_state != S_DONE) ? '0 : (r_mod ? w_rem_fix : w_quo_fix);

endmodule

`default_nettype wire

// File: tb/tb_ex_div_ctrl.sv
// Testbench for ex_div_ctrl: directed vector table plus cancel/reset sequences.
`default_nettype none

module tb_ex_div_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        div_req;
  logic [1:0]  div_op;
  logic [31:0] div_src1;
  logic [31:0] div_src2;
  logic        div_cancel;
  logic        ex_exe_out_valid;
  logic [31:0] div_result;
  logic        div_busy;

  int total = 0;
  int bad   = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam int EO = 1;
`else
  localparam int EO = 33;
`endif

  localparam logic [1:0] DIVW = 2'b00, MODW = 2'b01, DIVWU = 2'b10, MODWU = 2'b11;

  ex_div_ctrl #(.DATA_W(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .div_req          (div_req),
    .div_op           (div_op),
    .div_src1         (div_src1),
    .div_src2         (div_src2),
    .div_cancel       (div_cancel),
    .ex_exe_out_valid (ex_exe_out_valid),
    .div_result       (div_result),
    .div_busy         (div_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Samples each negedge starting with the current cycle (T0) until valid rises.
  task automatic wait_done(output int lat, output logic [31:0] res);
    lat = 0;
    res = '0;
    forever begin
      @(negedge clk);
      if (ex_exe_out_valid) begin
        res = div_result;
        break;
      end
      lat++;
      if (lat > 100) break;
    end
  endtask

  task automatic start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    div_req  = 1'b1;
    div_op   = op;
    div_src1 = a;
    div_src2 = b;
  endtask

  task automatic finish_op;
    @(posedge clk); #1;
    div_req = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [31:0] res;

    vecs[0]  = '{DIVW,  32'd100,        32'd7,          32'd14,         33};
    vecs[1]  = '{MODW,  32'd100,        32'd7,          32'd2,          33};
    vecs[2]  = '{MODW,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   33};
    vecs[3]  = '{DIVW,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   33};
    vecs[4]  = '{DIVWU, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   33};
    vecs[5]  = '{DIVW,  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   33};
    vecs[6]  = '{MODW,  32'h80000000,   32'hFFFFFFFF,   32'h0,          33};
    vecs[7]  = '{DIVW,  32'h1234,       32'd0,          32'hFFFFFFFF,   1};
    vecs[8]  = '{MODWU, 32'h1234,       32'd0,          32'h1234,       1};
    vecs[9]  = '{MODW,  32'hFFFFFFF9,   32'd0,          32'hFFFFFFF9,   1};
    vecs[10] = '{DIVW,  32'hFFFFFFF9,   32'd0,          32'hFFFFFFFF,   1};
    vecs[11] = '{DIVW,  32'd5,          32'd9,          32'd0,          EO};
    vecs[12] = '{MODW,  32'd5,          32'd9,          32'd5,          EO};
    vecs[13] = '{MODW,  32'hFFFFFFFB,   32'd9,          32'hFFFFFFFB,   EO};
    vecs[14] = '{DIVW,  32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   33};
    vecs[15] = '{MODW,  32'd7,          32'hFFFFFFFE,   32'd1,          33};
    vecs[16] = '{MODWU, 32'hFFFFFFFF,   32'h10,         32'hF,          33};
    vecs[17] = '{DIVWU, 32'd9,          32'd3,          32'd3,          33};

    reset = 1'b1; div_req = 1'b0; div_op = 2'b00;
    div_src1 = '0; div_src2 = '0; div_cancel = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid",  {31'd0, ex_exe_out_valid}, 32'd1);
    check("rst_result", div_result, 32'd0);
    check("rst_busy",   {31'd0, div_busy}, 32'd0);
    div_req = 1'b1;
    #1;
    check("rst_valid_req", {31'd0, ex_exe_out_valid}, 32'd0);
    div_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      @(posedge clk); #1;
      start(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(lat, res);
      check($sformatf("lat[%0d]", i), lat, vecs[i].lat);
      check($sformatf("res[%0d]", i), res, vecs[i].exp);
      finish_op();
    end

    // Cancel at T10, then an immediate div.wu 9/3 starting at T11.
    @(posedge clk); #1;
    start(DIVW, 32'd100, 32'd7);
    @(negedge clk);
    check("t0_valid", {31'd0, ex_exe_out_valid}, 32'd0);
    @(negedge clk);
    check("t1_busy", {31'd0, div_busy}, 32'd1);
    repeat (9) @(posedge clk);
    #1;
    div_cancel = 1'b1;
    @(negedge clk);
    check("cancel_valid", {31'd0, ex_exe_out_valid}, 32'd1);
    check("cancel_result", div_result, 32'd0);
    @(posedge clk); #1;
    div_cancel = 1'b0;
    start(DIVWU, 32'd9, 32'd3);
    wait_done(lat, res);
    check("after_cancel_lat", lat, 32'd33);
    check("after_cancel_res", res, 32'd3);
    finish_op();

    // Reset mid-operation discards state.
    @(posedge clk); #1;
    start(MODW, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    div_req = 1'b0;
    @(negedge clk);
    check("midrst_busy", {31'd0, div_busy}, 32'd0);
    check("midrst_result", div_result, 32'd0);
    check("midrst_valid", {31'd0, ex_exe_out_valid}, 32'd1);

    // Fresh op after reset still computes correctly.
    @(posedge clk); #1;
    start(MODW, 32'd100, 32'd7);
    wait_done(lat, res);
    check("post_rst_lat", lat, 32'd33);
    check("post_rst_res", res, 32'd2);
    finish_op();
    @(negedge clk);
    check("idle_result", div_result, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
